if_id_stage: RTL

//   Fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline; directly feeds ID_EX.

---
 rtl/if_id_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_id_stage : PC, instruction fetch and IF/ID register with load-use stall,
//               ID-resolved redirect flush and saturating event counters.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_valid,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   input  logic             mem_read_EX,
   input  logic [4:0]       rt_EX,
   output logic [31:0]      instr_ID,
   output logic [31:0]      pc4_ID,
   output logic [4:0]       rs_ID,
   output logic [4:0]       rt_ID,
   output logic [4:0]       rd_ID,
   output logic             id_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc4_q, pc4_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic [31:0] w_pc_plus4;
   logic        w_hazard;
   logic        w_redirect;
   logic [31:0] w_target;

   assign w_pc_plus4 = pc_q + 32'd4;
   assign w_hazard   = mem_read_EX && (rt_EX != 5'd0) &&
                       ((rt_EX == instr_q[25:21]) || (rt_EX == instr_q[20:16]));
   assign w_redirect = branch_taken || jump;
   // Branch wins over jump; targets are forced to word alignment.
   assign w_target   = branch_taken ? {branch_target[31:2], 2'b00}
                                    : {jump_target[31:2], 2'b00};

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      stall_d = stall_q;
      flush_d = flush_q;
      if (w_hazard) begin
         stall_d = (stall_q == {CNT_W{1'b1}}) ? stall_q : stall_q + c_CNT_ONE;
      end else if (w_redirect) begin
         pc_d    = w_target;
         instr_d = NOP;
         pc4_d   = 32'd0;
         flush_d = (flush_q == {CNT_W{1'b1}}) ? flush_q : flush_q + c_CNT_ONE;
      end else if (!imem_valid) begin
         instr_d = NOP;
         pc4_d   = 32'd0;
      end else begin
         pc_d    = w_pc_plus4;
         instr_d = imem_rdata;
         pc4_d   = w_pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         pc4_q   <= 32'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign imem_addr = pc_q;
   assign instr_ID  = instr_q;
   assign pc4_ID    = pc4_q;
   assign rs_ID     = instr_q[25:21];
   assign rt_ID     = instr_q[20:16];
   assign rd_ID     = instr_q[15:11];
   assign id_bubble = w_hazard;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule
`default_nettype wire
